// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the multi-lane hazard scoreboard.
// Holds the forward-select encodings, the lane/select width functions and the defer FSM states.
package hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_M    = 2'b01;
    localparam logic [1:0] FWD_W    = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } defer_state_e;

    // Lane-index field width; at least one bit even for a single lane.
    function automatic int lane_w(input int lanes);
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

    function automatic int fwd_w(input int lanes);
        return 2 + lane_w(lanes);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forwarding priority selector: M beats W, higher lane beats lower, r0 never forwards.
// Output is {stage code, source lane}.
module hazard_fwd_sel
    import hazard_scoreboard_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]         src,
    input  logic [LANES-1:0]          regwrite_m,
    input  logic [LANES*REG_AW-1:0]   writereg_m,
    input  logic [LANES-1:0]          regwrite_w,
    input  logic [LANES*REG_AW-1:0]   writereg_w,
    output logic [fwd_w(LANES)-1:0]   sel
);

    localparam int LW = lane_w(LANES);

    // Later assignments override earlier ones, so scanning W then M in
    // ascending lane order gives M-over-W and younger-lane-wins priority.
    always_comb begin
        sel = '0;
        if (src != '0) begin
            for (int i = 0; i < LANES; i++) begin
                if (regwrite_w[i] && (writereg_w[i*REG_AW +: REG_AW] == src)) begin
                    sel = {FWD_W, LW'(i)};
                end
            end
            for (int i = 0; i < LANES; i++) begin
                if (regwrite_m[i] && (writereg_m[i*REG_AW +: REG_AW] == src)) begin
                    sel = {FWD_M, LW'(i)};
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-lane hazard unit: forwarding, load-latency scoreboard, stall/flush generation,
// deferred mispredict flush across long stalls, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           i_cache_stall,
    input  logic                           d_cache_stall,
    input  logic                           alu_stallE,
    input  logic                           flush_jump_conflictE,
    input  logic                           flush_pred_failedM,
    input  logic                           flush_exceptionM,
    input  logic [LANES-1:0]               validD,
    input  logic [LANES*REG_AW-1:0]        rsD,
    input  logic [LANES*REG_AW-1:0]        rtD,
    input  logic [LANES-1:0]               mem_readD,
    input  logic [LANES-1:0]               regwriteD,
    input  logic [LANES*REG_AW-1:0]        writeregD,
    input  logic [LANES*REG_AW-1:0]        rsE,
    input  logic [LANES*REG_AW-1:0]        rtE,
    input  logic [LANES-1:0]               regwriteM,
    input  logic [LANES-1:0]               regwriteW,
    input  logic [LANES*REG_AW-1:0]        writeregM,
    input  logic [LANES*REG_AW-1:0]        writeregW,
    output logic                           stallF,
    output logic                           stallD,
    output logic                           stallE,
    output logic                           stallM,
    output logic                           stallW,
    output logic                           flushF,
    output logic                           flushD,
    output logic                           flushE,
    output logic                           flushM,
    output logic                           flushW,
    output logic                           longest_stall,
    output logic                           load_use_stall,
    output logic [LANES*fwd_w(LANES)-1:0]  forward_rsE,
    output logic [LANES*fwd_w(LANES)-1:0]  forward_rtE,
    output logic [CNT_W-1:0]               perf_stall_cnt,
    output defer_state_e                   defer_state
);

    localparam int FW   = fwd_w(LANES);
    localparam int CW   = $clog2(LOAD_LAT + 1);
    localparam int NREG = 1 << REG_AW;
    localparam logic [CW-1:0] LAT_V = CW'(LOAD_LAT);
    localparam logic [CW-1:0] ONE_V = CW'(1);

    logic [CW-1:0]        sb     [NREG];
    logic [CW-1:0]        sb_nxt [NREG];
    defer_state_e         state, state_nxt;
    logic                 ls, ls_mem, lu_raw, pred_eff, pred_flush, advance;
    logic [LANES*FW-1:0]  fwd_rs_raw, fwd_rt_raw;
    logic [CNT_W-1:0]     cnt;

    assign ls     = i_cache_stall | d_cache_stall | alu_stallE;
    assign ls_mem = i_cache_stall | d_cache_stall;
    assign longest_stall = ls;

    always_comb begin
        lu_raw = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (validD[i]) begin
                if ((rsD[i*REG_AW +: REG_AW] != '0) && (sb[rsD[i*REG_AW +: REG_AW]] != '0)) lu_raw = 1'b1;
                if ((rtD[i*REG_AW +: REG_AW] != '0) && (sb[rtD[i*REG_AW +: REG_AW]] != '0)) lu_raw = 1'b1;
            end
        end
    end

    // Reset forces every flush high and every stall low so the pipe drains cleanly.
    assign load_use_stall = resetn & ~flush_exceptionM & lu_raw;
    assign stallF = resetn & ~flush_exceptionM & (ls | load_use_stall);
    assign stallD = resetn & (ls | load_use_stall);
    assign stallE = resetn & ls;
    assign stallM = resetn & ls_mem;
    assign stallW = resetn & ~flush_exceptionM & ls_mem;

    assign pred_eff   = flush_pred_failedM | (state == ST_HOLD);
    assign pred_flush = pred_eff & ~ls;

    assign flushF = ~resetn;
    assign flushD = ~resetn | flush_exceptionM | pred_eff | (flush_jump_conflictE & ~stallD);
    assign flushE = ~resetn | flush_exceptionM | ((pred_eff | load_use_stall) & ~ls);
    assign flushM = ~resetn | flush_exceptionM;
    assign flushW = ~resetn | flush_exceptionM;

    assign advance = ~stallD & ~flushD;

    // A counter still at LOAD_LAT belongs to a load sitting in E, which a
    // mispredict flush squashes; new entries override the decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) sb_nxt[r] = sb[r];
        if (flush_exceptionM) begin
            for (int r = 0; r < NREG; r++) sb_nxt[r] = '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (pred_flush && (sb[r] == LAT_V)) sb_nxt[r] = '0;
                else if (!stallE && (sb[r] != '0)) sb_nxt[r] = sb[r] - ONE_V;
            end
            if (advance) begin
                for (int i = 0; i < LANES; i++) begin
                    if (validD[i] && mem_readD[i] && regwriteD[i] &&
                        (writeregD[i*REG_AW +: REG_AW] != '0)) begin
                        sb_nxt[writeregD[i*REG_AW +: REG_AW]] = LAT_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) sb[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) sb[r] <= sb_nxt[r];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (flush_pred_failedM && ls && !flush_exceptionM) state_nxt = ST_HOLD;
            ST_HOLD: if (flush_exceptionM || !ls) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    assign defer_state = state;

    always_ff @(posedge clk) begin
        if (!resetn)                     cnt <= '0;
        else if (stallD && (cnt != '1))  cnt <= cnt + CNT_W'(1);
    end

    assign perf_stall_cnt = cnt;

    for (genvar g = 0; g < LANES; g++) begin : g_fwd
        hazard_fwd_sel #(.LANES(LANES), .REG_AW(REG_AW)) u_rs (
            .src        (rsE[g*REG_AW +: REG_AW]),
            .regwrite_m (regwriteM),
            .writereg_m (writeregM),
            .regwrite_w (regwriteW),
            .writereg_w (writeregW),
            .sel        (fwd_rs_raw[g*FW +: FW])
        );
        hazard_fwd_sel #(.LANES(LANES), .REG_AW(REG_AW)) u_rt (
            .src        (rtE[g*REG_AW +: REG_AW]),
            .regwrite_m (regwriteM),
            .writereg_m (writeregM),
            .regwrite_w (regwriteW),
            .writereg_w (writeregW),
            .sel        (fwd_rt_raw[g*FW +: FW])
        );
    end

    assign forward_rsE = resetn ? fwd_rs_raw : '0;
    assign forward_rtE = resetn ? fwd_rt_raw : '0;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding vector table plus hand-written
// load-use, cache-stall, mispredict-defer, exception and counter-saturation sequences.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_cache_stall, d_cache_stall, alu_stallE;
    logic        flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
    logic [1:0]  validD, mem_readD, regwriteD, regwriteM, regwriteW;
    logic [9:0]  rsD, rtD, writeregD, rsE, rtE, writeregM, writeregW;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic        longest_stall, load_use_stall;
    logic [5:0]  forward_rsE, forward_rtE;
    logic [31:0] perf_stall_cnt;
    defer_state_e defer_state;

    logic [4:0]  s_stall, s_flush;
    logic        s_ls, s_lu;
    logic [5:0]  s_frs, s_frt;
    logic [3:0]  s_cnt;
    defer_state_e s_state;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        logic [9:0] rse;
        logic [9:0] rte;
        logic [1:0] rwm;
        logic [9:0] wrm;
        logic [1:0] rww;
        logic [9:0] wrw;
        logic [5:0] exp_rs;
        logic [5:0] exp_rt;
    } fwd_vec_t;

    fwd_vec_t vecs[7];

    always #5 clk = ~clk;

    hazard_scoreboard #(.LANES(2), .REG_AW(5), .LOAD_LAT(2), .CNT_W(32)) u_dut (
        .clk(clk), .resetn(resetn),
        .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall), .alu_stallE(alu_stallE),
        .flush_jump_conflictE(flush_jump_conflictE), .flush_pred_failedM(flush_pred_failedM),
        .flush_exceptionM(flush_exceptionM),
        .validD(validD), .rsD(rsD), .rtD(rtD), .mem_readD(mem_readD), .regwriteD(regwriteD),
        .writeregD(writeregD), .rsE(rsE), .rtE(rtE),
        .regwriteM(regwriteM), .regwriteW(regwriteW), .writeregM(writeregM), .writeregW(writeregW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .longest_stall(longest_stall), .load_use_stall(load_use_stall),
        .forward_rsE(forward_rsE), .forward_rtE(forward_rtE),
        .perf_stall_cnt(perf_stall_cnt), .defer_state(defer_state)
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    hazard_scoreboard #(.LANES(2), .REG_AW(5), .LOAD_LAT(2), .CNT_W(4)) u_sat (
        .clk(clk), .resetn(resetn),
        .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall), .alu_stallE(alu_stallE),
        .flush_jump_conflictE(flush_jump_conflictE), .flush_pred_failedM(flush_pred_failedM),
        .flush_exceptionM(flush_exceptionM),
        .validD(validD), .rsD(rsD), .rtD(rtD), .mem_readD(mem_readD), .regwriteD(regwriteD),
        .writeregD(writeregD), .rsE(rsE), .rtE(rtE),
        .regwriteM(regwriteM), .regwriteW(regwriteW), .writeregM(writeregM), .writeregW(writeregW),
        .stallF(s_stall[0]), .stallD(s_stall[1]), .stallE(s_stall[2]), .stallM(s_stall[3]),
        .stallW(s_stall[4]),
        .flushF(s_flush[0]), .flushD(s_flush[1]), .flushE(s_flush[2]), .flushM(s_flush[3]),
        .flushW(s_flush[4]),
        .longest_stall(s_ls), .load_use_stall(s_lu),
        .forward_rsE(s_frs), .forward_rtE(s_frt),
        .perf_stall_cnt(s_cnt), .defer_state(s_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_idle();
        i_cache_stall = 0; d_cache_stall = 0; alu_stallE = 0;
        flush_jump_conflictE = 0; flush_pred_failedM = 0; flush_exceptionM = 0;
        validD = 0; rsD = 0; rtD = 0; mem_readD = 0; regwriteD = 0; writeregD = 0;
        rsE = 0; rtE = 0; regwriteM = 0; regwriteW = 0; writeregM = 0; writeregW = 0;
    endtask

    task automatic drive_d(input int lane, input logic [4:0] rs, input logic [4:0] rt,
                           input logic mr, input logic rw, input logic [4:0] wr);
        validD[lane] = 1'b1;
        rsD[lane*5 +: 5] = rs;
        rtD[lane*5 +: 5] = rt;
        mem_readD[lane] = mr;
        regwriteD[lane] = rw;
        writeregD[lane*5 +: 5] = wr;
    endtask

    initial begin
        vecs[0] = '{10'({5'd0, 5'd8}), 10'd0, 2'b10, 10'({5'd8, 5'd0}), 2'b01, 10'({5'd0, 5'd8}),
                    6'b000_011, 6'b000_000};
        vecs[1] = '{10'd0, 10'd0, 2'b11, 10'd0, 2'b11, 10'd0, 6'b000_000, 6'b000_000};
        vecs[2] = '{10'({5'd3, 5'd0}), 10'({5'd0, 5'd3}), 2'b00, 10'd0, 2'b11, 10'({5'd3, 5'd3}),
                    6'b101_000, 6'b000_101};
        vecs[3] = '{10'({5'd0, 5'd7}), 10'({5'd7, 5'd0}), 2'b01, 10'({5'd0, 5'd7}), 2'b10,
                    10'({5'd7, 5'd0}), 6'b000_010, 6'b010_000};
        vecs[4] = '{10'({5'd0, 5'd9}), 10'({5'd9, 5'd0}), 2'b00, 10'({5'd9, 5'd9}), 2'b00,
                    10'({5'd9, 5'd9}), 6'b000_000, 6'b000_000};
        vecs[5] = '{10'({5'd0, 5'd4}), 10'({5'd4, 5'd0}), 2'b11, 10'({5'd4, 5'd4}), 2'b00, 10'd0,
                    6'b000_011, 6'b011_000};
        vecs[6] = '{10'({5'd5, 5'd2}), 10'({5'd2, 5'd5}), 2'b10, 10'({5'd5, 5'd6}), 2'b01,
                    10'({5'd0, 5'd2}), 6'b011_100, 6'b100_011};

        // Reset with hazards present on the inputs.
        resetn = 0;
        drive_idle();
        i_cache_stall = 1; flush_pred_failedM = 1;
        rsE = 10'd8; regwriteM = 2'b01; writeregM = 10'd8;
        tick(); tick(); settle();
        check("rst_flushF", flushF, 1);
        check("rst_flushD", flushD, 1);
        check("rst_flushE", flushE, 1);
        check("rst_flushM", flushM, 1);
        check("rst_flushW", flushW, 1);
        check("rst_stallF", stallF, 0);
        check("rst_stallD", stallD, 0);
        check("rst_stallM", stallM, 0);
        check("rst_stallW", stallW, 0);
        check("rst_lu", load_use_stall, 0);
        check("rst_fwd_rs", forward_rsE, 0);
        check("rst_perf", perf_stall_cnt, 0);
        check("rst_state", defer_state, ST_RUN);
        resetn = 1;
        drive_idle();
        tick();

        // Forwarding table.
        for (int i = 0; i < 7; i++) begin
            rsE = vecs[i].rse; rtE = vecs[i].rte;
            regwriteM = vecs[i].rwm; writeregM = vecs[i].wrm;
            regwriteW = vecs[i].rww; writeregW = vecs[i].wrw;
            exp_q.push_back(vecs[i].exp_rs);
            exp_q.push_back(vecs[i].exp_rt);
            settle();
            check($sformatf("fwd_rs[%0d]", i), forward_rsE, exp_q.pop_front());
            check($sformatf("fwd_rt[%0d]", i), forward_rtE, exp_q.pop_front());
            tick();
        end

        // Load r5 then consumer: two load-use cycles, then advance.
        drive_idle();
        drive_d(0, 5'd0, 5'd0, 1, 1, 5'd5);
        settle();
        check("lu_load_adv", stallD, 0);
        tick();
        drive_idle();
        drive_d(0, 5'd5, 5'd0, 0, 1, 5'd6);
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("lu_stall[%0d]", c), load_use_stall, 1);
            check($sformatf("lu_flushE[%0d]", c), flushE, 1);
            check($sformatf("lu_stallE[%0d]", c), stallE, 0);
            tick();
        end
        rsE = 10'd5; regwriteW = 2'b01; writeregW = 10'd5;
        settle();
        check("lu_release", load_use_stall, 0);
        check("lu_stallD_rel", stallD, 0);
        check("lu_fwd_w", forward_rsE, 6'b000_100);
        check("lu_perf", perf_stall_cnt, 2);
        tick();

        // Load r5 on lane1, then four d-cache stall cycles freeze the counter.
        drive_idle();
        drive_d(1, 5'd0, 5'd0, 1, 1, 5'd5);
        tick();
        drive_idle();
        drive_d(0, 5'd0, 5'd5, 0, 0, 5'd0);
        d_cache_stall = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("dc_stallD[%0d]", c), stallD, 1);
            check($sformatf("dc_flushE[%0d]", c), flushE, 0);
            tick();
        end
        d_cache_stall = 0;
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("dc_lu[%0d]", c), load_use_stall, 1);
            check($sformatf("dc_lu_flushE[%0d]", c), flushE, 1);
            tick();
        end
        settle();
        check("dc_lu_done", load_use_stall, 0);
        check("dc_perf", perf_stall_cnt, 8);
        tick();

        // Mispredict during a 3-cycle ALU stall is deferred.
        drive_idle();
        alu_stallE = 1; flush_pred_failedM = 1;
        settle();
        check("mp_state0", defer_state, ST_RUN);
        check("mp_flushD0", flushD, 1);
        check("mp_flushE0", flushE, 0);
        tick();
        flush_pred_failedM = 0;
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("mp_hold[%0d]", c), defer_state, ST_HOLD);
            check($sformatf("mp_flushD[%0d]", c), flushD, 1);
            check($sformatf("mp_flushE[%0d]", c), flushE, 0);
            tick();
        end
        alu_stallE = 0;
        settle();
        check("mp_fire_flushE", flushE, 1);
        check("mp_fire_flushD", flushD, 1);
        tick();
        settle();
        check("mp_back_run", defer_state, ST_RUN);
        check("mp_after_flushE", flushE, 0);
        check("mp_after_flushD", flushD, 0);
        check("mp_perf", perf_stall_cnt, 11);
        tick();

        // Mispredict squashes a load that just entered E.
        drive_idle();
        drive_d(0, 5'd0, 5'd0, 1, 1, 5'd9);
        tick();
        drive_idle();
        flush_pred_failedM = 1;
        settle();
        check("sq_flushE", flushE, 1);
        tick();
        drive_idle();
        drive_d(0, 5'd9, 5'd0, 0, 0, 5'd0);
        settle();
        check("sq_no_lu", load_use_stall, 0);
        tick();

        // Exception while holding a deferred mispredict.
        drive_idle();
        drive_d(0, 5'd0, 5'd0, 1, 1, 5'd12);
        tick();
        drive_idle();
        alu_stallE = 1; flush_pred_failedM = 1;
        tick();
        flush_pred_failedM = 0; flush_exceptionM = 1; i_cache_stall = 1;
        drive_d(0, 5'd12, 5'd0, 0, 0, 5'd0);
        settle();
        check("ex_in_hold", defer_state, ST_HOLD);
        check("ex_flushD", flushD, 1);
        check("ex_flushE", flushE, 1);
        check("ex_flushM", flushM, 1);
        check("ex_flushW", flushW, 1);
        check("ex_stallF", stallF, 0);
        check("ex_stallW", stallW, 0);
        check("ex_lu", load_use_stall, 0);
        tick();
        drive_idle();
        drive_d(0, 5'd12, 5'd0, 0, 0, 5'd0);
        settle();
        check("ex_state_run", defer_state, ST_RUN);
        check("ex_sb_cleared", load_use_stall, 0);
        check("ex_perf", perf_stall_cnt, 13);
        check("sat_pre", s_cnt, 13);
        tick();

        // Hold stallD five cycles: narrow counter saturates at 15.
        drive_idle();
        alu_stallE = 1; flush_pred_failedM = 1;
        tick();
        flush_pred_failedM = 0;
        repeat (4) tick();
        settle();
        check("sat_wide", perf_stall_cnt, 18);
        check("sat_narrow", s_cnt, 15);
        check("sat_hold", defer_state, ST_HOLD);

        // Reset in the middle of HOLD.
        resetn = 0;
        settle();
        check("rh_flushD", flushD, 1);
        check("rh_stallD", stallD, 0);
        tick();
        settle();
        check("rh_state", defer_state, ST_RUN);
        check("rh_perf", perf_stall_cnt, 0);
        check("rh_sat", s_cnt, 0);
        resetn = 1;
        alu_stallE = 0;
        settle();
        check("rh_no_defer", flushD, 0);
        tick();
        settle();
        check("rh_state_after", defer_state, ST_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised multi-lane successor of the single-issue hazard unit. It sits beside the D/E/M/W pipeline registers and owns five jobs: per-lane operand forwarding, load-use detection via a per-register latency scoreboard, stall/flush generation, deferral of branch-mispredict flushes that arrive during a long stall, and a saturating stall-cycle performance counter.

Parameters:
LANES, 2, number of issue lanes (1..4)
REG_AW, 5, architectural register index width
LOAD_LAT, 2, advancing cycles after E-entry before load data is forwardable (1..3)
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
i_cache_stall  in  1  instruction cache busy
d_cache_stall  in  1  data cache busy
alu_stallE  in  1  multicycle ALU busy in E
flush_jump_conflictE  in  1  jump conflict resolved in E
flush_pred_failedM  in  1  branch mispredict resolved in M
flush_exceptionM  in  1  exception committed in M
validD  in  LANES  lane holds an instruction in D
rsD, rtD  in  LANES*REG_AW  D-stage source registers, lane i at [i*REG_AW +: REG_AW]
mem_readD, regwriteD  in  LANES  D-stage load flag, D-stage write-enable
writeregD  in  LANES*REG_AW  D-stage destination register
rsE, rtE  in  LANES*REG_AW  E-stage source registers
regwriteM, regwriteW  in  LANES  write enables in M, W
writeregM, writeregW  in  LANES*REG_AW  destination registers in M, W
stallF, stallD, stallE, stallM, stallW  out  1  stage holds
flushF, flushD, flushE, flushM, flushW  out  1  stage squashes
longest_stall  out  1  i_cache_stall | d_cache_stall | alu_stallE
load_use_stall  out  1  D held for a pending load
forward_rsE, forward_rtE  out  LANES*FW  per-lane select; FW = 2 + LW, LW = max(1, clog2(LANES)); field [FW-1 -: 2]: 00 none, 01 M, 10 W; low LW bits = source lane
perf_stall_cnt  out  CNT_W  cycles with stallD = 1

Behaviour:
- Reset (resetn = 0 at posedge): scoreboard counters = 0, FSM = RUN, perf_stall_cnt = 0. While resetn = 0, all flush outputs = 1, all stall outputs = 0, load_use_stall = 0, forward selects = 0.
- Forwarding (combinational), per lane and operand:
  - Register 0 never forwards, for both rs and rt.
  - Any M-stage match beats any W-stage match.
  - Within one stage, the higher lane index (younger) wins.
  - Ties resolve deterministically by that order.
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1).
  - On a D->E advance (~stallD & ~flushD) of lane i with validD & mem_readD & regwriteD & writeregD != 0, set counter[writeregD] = LOAD_LAT.
  - Lane order resolves duplicate destinations; the result is the same value either way.
  - Every cycle with ~stallE, all nonzero counters decrement, except entries being set that cycle.
  - flush_exceptionM clears all counters.
  - An effective mispredict flushE clears counters still equal to LOAD_LAT (loads squashed in E).
  - load_use_stall = OR over valid D lanes of (counter[rsD] != 0 or counter[rtD] != 0), with register 0 excluded; forced 0 while flush_exceptionM.
- Stall equations:
  - stallF = ~flush_exceptionM & (longest_stall | load_use_stall)
  - stallD = longest_stall | load_use_stall
  - stallE = longest_stall
  - stallM = i_cache_stall | d_cache_stall
  - stallW = ~flush_exceptionM & (i_cache_stall | d_cache_stall)
- Mispredict defer FSM:
  - States: RUN, HOLD.
  - RUN->HOLD when flush_pred_failedM & longest_stall & ~flush_exceptionM.
  - HOLD->RUN when ~longest_stall (the deferred flush fires that cycle) or when flush_exceptionM (exception supersedes; pending flush dropped).
  - Define pred_eff = flush_pred_failedM | (state == HOLD).
  - A new mispredict arriving in HOLD merges: stay in HOLD.
- Flush equations:
  - flushF = 0
  - flushD = flush_exceptionM | pred_eff | (flush_jump_conflictE & ~stallD)
  - flushE = flush_exceptionM | ((pred_eff | load_use_stall) & ~longest_stall)
  - flushM = flushW = flush_exceptionM
- perf_stall_cnt: increments when stallD = 1 and saturates at all-ones.

Decomposition:
- Shared package holds FW/LW derivation functions, forward-select encodings (FWD_NONE = 2'b00, FWD_M = 2'b01, FWD_W = 2'b10) and FSM state enum.
- One natural sub-module: hazard_fwd_sel, the single-operand priority selector (operand register, LANES-wide M/W enables and destinations -> FW-bit select). It is instantiated 2*LANES times.

Test Plan:
1. Lane0 in E has rsE = 8; lane1 in M and lane0 in W both write r8 -> forward_rsE lane0 = {01, lane 1}; with rsE = 0 and writeregM = 0 -> 00.
2. Load r5 enters E with LOAD_LAT = 2, next D reads r5 -> load_use_stall = 1 for 2 cycles, flushE = 1 each cycle; third cycle the consumer advances with W-forward select 10.
3. Same load with d_cache_stall high for 4 cycles -> counter frozen at 2, flushE = 0 during the stall, stallD = 1, perf_stall_cnt advances by 4 plus the load-use cycles.
4. flush_pred_failedM pulsed while alu_stallE = 1 for 3 cycles -> HOLD, flushD held 1, flushE = 0 until alu_stallE falls, then flushE = 1 for exactly 1 cycle, FSM back to RUN.
5. In HOLD, flush_exceptionM = 1 -> all counters 0, FSM = RUN, flushD/E/M/W = 1, stallF = stallW = 0 even with i_cache_stall = 1.
6. Preload perf_stall_cnt near max (CNT_W = 4), hold stallD -> saturates at 15; resetn low mid-HOLD -> RUN, counter 0.
